// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline control unit.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bits needed to hold max_val; never below 2 so a one-hot "1" constant can be built.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 2;
    for (int i = 2; i < 32; i++) begin
      if ((max_val >> i) != 32'd0) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an IF/ID instruction that reads the
// destination of the load currently in ID/EX. Register 0 never hazards.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic       fd_uses_rt,
  input  logic       de_mem_read,
  input  logic [4:0] de_dst_reg,
  output logic       lu_stall
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (de_dst_reg == fd_rs);
  assign rt_match = fd_uses_rt & (de_dst_reg == fd_rt);
  assign lu_stall = de_mem_read & (de_dst_reg != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: warm-up hold, load-use stall, MEM-stage redirect and
// data-memory freeze. Optional counters enabled by PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_uses_rt,
  input  logic        de_mem_read,
  input  logic [4:0]  de_dst_reg,
  input  logic        em_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_wren,
  output logic        fd_wren,
  output logic        de_wren,
  output logic        em_wren,
  output logic        mw_wren,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        pc_sel_branch,
  output logic        mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int unsigned WAIT_W = cnt_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [3:0]        HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [3:0]        hold_cnt;
  logic [3:0]        hold_cnt_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_flag;
  logic              timeout_next;
  logic              mem_stall;
  logic              lu_stall;

  hazard_detect u_hazard_detect (
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rt (fd_uses_rt),
    .de_mem_read(de_mem_read),
    .de_dst_reg (de_dst_reg),
    .lu_stall   (lu_stall)
  );

  // State, hold/wait counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      hold_cnt     <= 4'd0;
      wait_cnt     <= WAIT_ZERO;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_cnt_next;
      wait_cnt     <= wait_cnt_next;
      timeout_flag <= timeout_next;
    end
  end

  // Next-state and control outputs; MEM_WAIT with ack behaves exactly like RUN.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    wait_cnt_next = wait_cnt;
    mem_stall     = 1'b0;
    pc_wren       = 1'b0;
    fd_wren       = 1'b0;
    de_wren       = 1'b0;
    em_wren       = 1'b0;
    mw_wren       = 1'b0;
    fd_flush      = 1'b0;
    de_flush      = 1'b0;
    em_flush      = 1'b0;
    pc_sel_branch = 1'b0;

    case (state)
      HOLD: begin
        wait_cnt_next = WAIT_ZERO;
        if (hold_cnt == HOLD_LAST) begin
          state_next    = RUN;
          hold_cnt_next = 4'd0;
        end else begin
          hold_cnt_next = hold_cnt + 4'd1;
        end
      end
      RUN, MEM_WAIT: begin
        if (state == MEM_WAIT) begin
          mem_stall = ~mem_ack;
        end else begin
          mem_stall = mem_req & ~mem_ack;
        end

        if (mem_stall) begin
          state_next = MEM_WAIT;
          if (state == RUN) begin
            wait_cnt_next = WAIT_ONE;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt_next = wait_cnt + WAIT_ONE;
          end else begin
            wait_cnt_next = wait_cnt;
          end
        end else begin
          state_next    = RUN;
          wait_cnt_next = WAIT_ZERO;
          pc_wren       = 1'b1;
          fd_wren       = 1'b1;
          de_wren       = 1'b1;
          em_wren       = 1'b1;
          mw_wren       = 1'b1;
          // A redirect flushes the hazarding instructions, so it masks load-use.
          if (em_redirect) begin
            pc_sel_branch = 1'b1;
            fd_flush      = 1'b1;
            de_flush      = 1'b1;
            em_flush      = 1'b1;
          end else if (lu_stall) begin
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_flush = 1'b1;
          end else begin
            pc_sel_branch = 1'b0;
          end
        end
      end
      default: begin
        state_next    = HOLD;
        hold_cnt_next = 4'd0;
        wait_cnt_next = WAIT_ZERO;
      end
    endcase

    timeout_next = timeout_flag | (wait_cnt_next == WAIT_MAX);
  end

  assign mem_timeout = timeout_flag;

`ifdef PIPELINE_CTRL_PERF_EN
  // Performance counters; free-running, wrap modulo 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if ((state != HOLD) && !pc_wren) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (pc_sel_branch) begin
        flush_events <= flush_events + 32'd1;
      end else begin
        flush_events <= flush_events;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-scenario tasks with a scoreboard queue.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mr;
    logic [4:0] dst;
    logic       redir;
    logic       req;
    logic       ack;
  } stim_t;

  // {pc,fd,de,em,mw wren, fd,de,em flush, pc_sel_branch, mem_timeout}
  localparam logic [9:0] E_ZERO  = 10'b00000_000_0_0;
  localparam logic [9:0] E_RUN   = 10'b11111_000_0_0;
  localparam logic [9:0] E_LU    = 10'b00111_010_0_0;
  localparam logic [9:0] E_REDIR = 10'b11111_111_1_0;
  localparam logic [9:0] E_TO    = 10'b00000_000_0_1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] fd_rs = 5'd0;
  logic [4:0] fd_rt = 5'd0;
  logic       fd_uses_rt = 1'b0;
  logic       de_mem_read = 1'b0;
  logic [4:0] de_dst_reg = 5'd0;
  logic       em_redirect = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_ack = 1'b0;
  logic       pc_wren, fd_wren, de_wren, em_wren, mw_wren;
  logic       fd_flush, de_flush, em_flush, pc_sel_branch, mem_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  pipeline_ctrl #(.RESET_HOLD_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
    .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg),
    .em_redirect(em_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren),
    .em_wren(em_wren), .mw_wren(mw_wren),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
    .pc_sel_branch(pc_sel_branch), .mem_timeout(mem_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt, input logic mr, input logic [4:0] dst,
                               input logic redir, input logic req, input logic ack);
    stim_t s;
    s.rst = rst; s.rs = rs; s.rt = rt; s.uses_rt = uses_rt; s.mr = mr;
    s.dst = dst; s.redir = redir; s.req = req; s.ack = ack;
    return s;
  endfunction

  function automatic logic [9:0] outs();
    return {pc_wren, fd_wren, de_wren, em_wren, mw_wren,
            fd_flush, de_flush, em_flush, pc_sel_branch, mem_timeout};
  endfunction

  task automatic drive(input stim_t s);
    reset_n = s.rst; fd_rs = s.rs; fd_rt = s.rt; fd_uses_rt = s.uses_rt;
    de_mem_read = s.mr; de_dst_reg = s.dst; em_redirect = s.redir;
    mem_req = s.req; mem_ack = s.ack;
  endtask

  task automatic test_reset();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    st.push_back(mk(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(mk(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0)); ex.push_back(E_LU);
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    st.push_back(mk(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0)); ex.push_back(E_LU);
    st.push_back(mk(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    st.push_back(mk(1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL load_use[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0)); ex.push_back(E_REDIR);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0)); ex.push_back(E_REDIR);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL redirect[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1)); ex.push_back(E_RUN);
    for (int k = 0; k < 3; k++) begin
      st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0)); ex.push_back(E_ZERO);
    end
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1)); ex.push_back(E_RUN);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL mem_wait[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1)); ex.push_back(E_REDIR);
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1)); ex.push_back(E_LU);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL priority[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    stim_t wt, ak, idle;
    wt   = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    ak   = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      st.push_back(wt); ex.push_back(E_ZERO);
    end
    st.push_back(wt);   ex.push_back(E_TO);
    st.push_back(wt);   ex.push_back(E_TO);
    st.push_back(ak);   ex.push_back(E_RUN | E_TO);
    st.push_back(idle); ex.push_back(E_RUN | E_TO);
    st.push_back(wt);   ex.push_back(E_TO);
    st.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(idle); ex.push_back(E_ZERO);
    st.push_back(idle); ex.push_back(E_ZERO);
    st.push_back(idle); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL timeout[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

`ifdef PIPELINE_CTRL_PERF_EN
  task automatic test_perf();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] got, want;
    logic [31:0] pq[$];
    logic [31:0] pgot, pwant;
    stim_t idle, lu;
    idle = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    lu   = mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    st.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(E_ZERO);
    st.push_back(idle); ex.push_back(E_ZERO);
    st.push_back(idle); ex.push_back(E_ZERO);
    st.push_back(lu);   ex.push_back(E_LU);
    st.push_back(idle); ex.push_back(E_RUN);
    st.push_back(lu);   ex.push_back(E_LU);
    st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0)); ex.push_back(E_REDIR);
    st.push_back(idle); ex.push_back(E_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #2;
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL perf_ctrl[%0d] got %b expected %b", i, got, want);
      end
    end
    pq.push_back(32'd2); pq.push_back(32'd1);
    pgot = stall_cycles; pwant = pq.pop_front(); checks++;
    if (pgot !== pwant) begin
      errors++; $display("FAIL stall_cycles got %0d expected %0d", pgot, pwant);
    end
    pgot = flush_events; pwant = pq.pop_front(); checks++;
    if (pgot !== pwant) begin
      errors++; $display("FAIL flush_events got %0d expected %0d", pgot, pwant);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_priority();
    test_timeout();
`ifdef PIPELINE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control unit for the five-stage core. It drives the write-enable and bubble-insert inputs of the PC and the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which only capture what they are told to. It resolves:
- load-use hazards, by stalling and inserting a bubble;
- taken branches and jumps resolved in MEM, by redirecting the PC and flushing the younger stages;
- data-memory wait states, by freezing the pipeline.

It also holds the pipeline idle for a fixed warm-up after reset.

## Interface
Parameters:
- RESET_HOLD_CYCLES, 2, number of cycles after reset release during which every enable stays low (1..15).
- MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles that sets `mem_timeout` (1..65535).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - reset_n  in  1  asynchronous active-low reset.
- Hazard-detection inputs:
  - fd_rs  in  5  rs field of the instruction in IF/ID.
  - fd_rt  in  5  rt field of the instruction in IF/ID.
  - fd_uses_rt  in  1  the IF/ID instruction reads rt.
  - de_mem_read  in  1  the ID/EX instruction is a load.
  - de_dst_reg  in  5  destination register of the ID/EX instruction.
- Branch input:
  - em_redirect  in  1  taken branch or jump in EX/MEM (dec_branch & alu_result_zero | dec_jmp).
- Data-memory handshake:
  - mem_req  in  1  the EX/MEM instruction accesses data memory.
  - mem_ack  in  1  data memory completes the access this cycle.
- Enable outputs:
  - pc_wren, fd_wren, de_wren, em_wren, mw_wren  out  1 each  enables for the PC and the four stage registers.
- Bubble and redirect outputs:
  - fd_flush, de_flush, em_flush  out  1 each  the register loads a NOP/zero bubble instead of its input. Valid only together with the matching wren.
  - pc_sel_branch  out  1  the PC loads branch_pc instead of next_pc.
- Status output:
  - mem_timeout  out  1  sticky flag; cleared only by reset.

## Operation
States: HOLD, RUN, MEM_WAIT. Priority inside RUN is memory wait > redirect > load-use.

- Reset:
  - Asynchronous entry into HOLD with the hold counter at 0.
  - All outputs are 0 during reset and throughout HOLD; mem_timeout is 0.
- HOLD:
  - Counts cycles; after RESET_HOLD_CYCLES cycles moves to RUN.
  - All enables stay 0 for the whole hold.
- RUN, default:
  - All five wren are 1; all flush outputs and pc_sel_branch are 0.
- RUN, memory request without ack (mem_req & !mem_ack):
  - All wren are 0 this cycle; next state is MEM_WAIT.
  - The wait counter loads 1.
- RUN, redirect (em_redirect and no memory wait):
  - pc_sel_branch=1; all wren are 1.
  - fd_flush, de_flush and em_flush are all 1.
  - Any load-use hazard in the same cycle is ignored, because the hazarding instructions are being flushed.
- RUN, load-use (no redirect and no memory wait):
  - The condition is de_mem_read & de_dst_reg!=0 & (de_dst_reg==fd_rs | fd_uses_rt & de_dst_reg==fd_rt).
  - pc_wren=0 and fd_wren=0.
  - de_wren=1 with de_flush=1; em_wren=1 and mw_wren=1.
- MEM_WAIT:
  - All wren are 0 while mem_ack is 0.
  - The wait counter increments and saturates at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set. The pipeline stays frozen; there is no abort.
- MEM_WAIT exit, when mem_ack=1:
  - The same cycle behaves exactly like RUN with the memory-wait term removed: redirect and load-use are evaluated normally.
  - Next state is RUN.
- Register 0 never causes a load-use stall.

## Timing
- All outputs are combinational from the current state plus the inputs; the state and counters are registered.
- A load-use hazard costs exactly 1 stall cycle. The next cycle, ID/EX holds the bubble and the hazard condition clears.
- A redirect costs 3 flushed instruction slots. The PC holds branch_pc on the following edge.
- A memory access completing with mem_ack in its first cycle costs 0 stall cycles; otherwise the cost is the number of ack-low cycles.
- Reset asserted mid-MEM_WAIT or mid-hold: state returns to HOLD immediately and the counters clear.

## Configuration
- PIPELINE_CTRL_PERF_EN defined:
  - Adds outputs stall_cycles[31:0] and flush_events[31:0]. Both reset to 0 and wrap modulo 2^32.
  - stall_cycles increments on every RUN or MEM_WAIT cycle in which pc_wren=0.
  - flush_events increments once per cycle with pc_sel_branch=1.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package pipeline_pkg:
  - the state encoding (HOLD, RUN, MEM_WAIT);
  - the REG_ZERO constant (5'd0);
  - the counter-width helper constant for MEM_TIMEOUT.
- One sub-module, hazard_detect: purely combinational load-use comparator with output lu_stall.
- The rest of the logic lives in pipeline_ctrl.

## Test plan
- Reset release with RESET_HOLD_CYCLES=2 → all wren=0 for 2 cycles after reset_n rises, then all 5 wren=1.
- de_mem_read=1, de_dst_reg=5, fd_rs=5 → one cycle of pc_wren=0, fd_wren=0, de_flush=1; with de_dst_reg=0 → no stall.
- em_redirect=1 together with a load-use hazard → pc_sel_branch=1, fd/de/em_flush=1, all wren=1, no stall.
- mem_req=1, mem_ack=0 for 3 cycles then 1 → all wren=0 for 3 cycles, then a normal advance; mem_timeout stays 0.
- MEM_TIMEOUT=4 with mem_ack held 0 → mem_timeout=1 after 4 wait cycles and stays high after the ack; reset_n low clears it.
- With PIPELINE_CTRL_PERF_EN: 2 load-use stalls plus 1 redirect → stall_cycles=2, flush_events=1.
